flash_tick_dir_gen: RTL and testbench
=====================================

// Module: flash_tick_dir_gen
// PURPOSE
//  Front-end for the LED flasher. Debounces three raw push-buttons and generates
//  the dir level and the one-cycle clk_bps step strobe that the flasher consumes.
//  Adds run/pause control and four step speeds.
//  Sits between board keys and the flasher; all outputs are registered in the clk domain.
// PARAMETERS
//  TICK_DIV  25_000_000  clk cycles per step at speed 0 (0.5 s @ 50 MHz); must be >= 8
//  DB_CNT    1_000_000   consecutive stable cycles needed to accept a key change (20 ms)
//  CNT_W     25          width of the tick counter; 2**CNT_W > TICK_DIV
// PORTS
//  clk        in   1      system clock
//  rst        in   1      asynchronous, active-low reset
//  key_dir    in   1      raw button, active-low (0 = pressed); a press toggles dir
//  key_speed  in   1      raw button, active-low; a press advances speed
//  key_pause  in   1      raw button, active-low; a press toggles paused
//  dir        out  1      0 = left-to-right, 1 = right-to-left
//  clk_bps    out  1      one-clk-wide step strobe
//  speed      out  2      current speed level 0..3
//  paused     out  1      1 = strobes suppressed
// BEHAVIOUR
//  Reset (rst=0, async): dir=0, clk_bps=0, speed=0, paused=0. Tick counter = 0.
//   Debounce counters = 0. Sync flops and debounced levels = 1 (released).
//  Synchroniser: each key passes through 2 flops (sync) before debounce.
//  Debounce, per key:
//   - If sync == level, db_cnt <= 0.
//   - Otherwise db_cnt increments.
//   - When db_cnt == DB_CNT-1 and sync still differs: level <= sync and db_cnt <= 0.
//   - A glitch shorter than DB_CNT cycles never changes level.
//  Press event: level goes 1->0. The action takes effect on that same clock edge.
//   Release (0->1) produces no action.
//  Latency: raw key low -> action = 2 + DB_CNT clk edges (+1 for async sample phase).
//  Actions:
//   - dir press: dir <= ~dir. The tick counter is not disturbed.
//   - speed press: speed <= speed+1, wrapping 3->0. The tick counter is cleared to 0.
//   - pause press: paused <= ~paused. The tick counter holds its value while paused.
//  Step period P = TICK_DIV >> speed, i.e. TICK_DIV, /2, /4, /8 (integer shift).
//  Tick counter, when not paused:
//   - At tcnt == P-1: tcnt <= 0 and clk_bps <= 1 for exactly one cycle.
//   - Otherwise tcnt <= tcnt+1 and clk_bps <= 0.
//   - Strobes are therefore exactly P cycles apart.
//  Paused: clk_bps = 0 and tcnt is frozen. On resume, counting continues from the frozen
//   value; the first strobe follows after (P-1-tcnt)+1 cycles.
//  Simultaneous events:
//   - All three keys are independent and may act on the same edge.
//   - Speed press and tcnt == P-1 on the same edge: the speed press wins. tcnt <= 0,
//     no strobe that cycle.
//   - Pause press and tcnt == P-1 on the same edge (entering pause): no strobe and
//     tcnt holds. Leaving pause: counting resumes on that edge.
//  Speed change to a shorter P while tcnt >= new P cannot occur, because tcnt is cleared.
//  Reset mid-debounce or mid-period: everything returns to reset values. A key still
//   held after reset release is seen as level 0 after DB_CNT cycles and counts as a press.
// TESTING  (TICK_DIV=16, DB_CNT=4)
//  1. Release reset, keys idle for 100 cycles -> clk_bps pulses at cycles 16, 32, 48...
//     after release; each pulse 1 cycle wide; dir=0, speed=0.
//  2. key_dir low for 2 cycles, then high -> dir stays 0 and no debounce acceptance.
//     Hold it low for 10 cycles -> dir=1 exactly 6 edges after first low sample, toggled once.
//  3. Three clean key_speed presses -> strobe spacing 8, 4, 2. A 4th press -> speed=0,
//     spacing 16. First strobe after each press arrives P cycles after the press edge.
//  4. key_pause press at tcnt=5 -> no clk_bps for 50 cycles. Press again -> next strobe
//     11 cycles after resume.
//  5. Press key_dir and key_speed in the same cycle, timed so acceptance lands on
//     tcnt==15 -> dir toggles, speed=1, no strobe, next strobe 8 cycles later.
//  6. Assert rst with key_dir held and tcnt=9 -> all outputs go to 0 immediately.
//     After release: dir=1 at edge 2+4, first strobe at cycle 16.

Source files
------------

// File: rtl/flash_tick_dir_gen_if.sv
// Bundle of key inputs and flasher-control outputs for flash_tick_dir_gen.
//   key_dir, key_speed, key_pause : raw active-low push-buttons (0 = pressed)
//   dir                           : 0 = left-to-right, 1 = right-to-left
//   clk_bps                       : one-clock-wide step strobe
//   speed                         : current speed level 0..3
//   paused                        : 1 = strobes suppressed
// master = board/key side (drives keys, observes controls)
// slave  = the generator (samples keys, drives controls)
interface flash_tick_dir_gen_if;
  logic       key_dir;
  logic       key_speed;
  logic       key_pause;
  logic       dir;
  logic       clk_bps;
  logic [1:0] speed;
  logic       paused;

  modport master (
    output key_dir, key_speed, key_pause,
    input  dir, clk_bps, speed, paused
  );

  modport slave (
    input  key_dir, key_speed, key_pause,
    output dir, clk_bps, speed, paused
  );
endinterface

// File: rtl/flash_tick_dir_gen.sv
// LED flasher front-end: synchronises and debounces three raw buttons and
// produces the dir level, the clk_bps step strobe, a 4-level speed setting
// and a run/pause state. All outputs are registers in the clk domain.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-low reset
//   bus  : flash_tick_dir_gen_if.slave (keys in, dir/clk_bps/speed/paused out)
// Parameters:
//   TICK_DIV : clk cycles per step at speed 0 (>= 8)
//   DB_CNT   : consecutive stable cycles needed to accept a key change
//   CNT_W    : tick counter width, 2**CNT_W > TICK_DIV
module flash_tick_dir_gen #(
  parameter int TICK_DIV = 25_000_000,
  parameter int DB_CNT   = 1_000_000,
  parameter int CNT_W    = 25
) (
  input  logic                 clk,
  input  logic                 rst,
  flash_tick_dir_gen_if.slave  bus
);

  localparam int              DB_W       = $clog2(DB_CNT + 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DB_CNT - 1);
  localparam logic [DB_W-1:0] DB_ONE     = DB_W'(1);
  localparam logic [CNT_W-1:0] TICK_DIV_C = CNT_W'(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Key index: 0 = dir, 1 = speed, 2 = pause
  localparam int K_DIR   = 0;
  localparam int K_SPEED = 1;
  localparam int K_PAUSE = 2;

  logic [2:0]            key_raw;
  logic [2:0]            key_p0;
  logic [2:0]            key_p1;
  logic [2:0]            level;
  logic [2:0][DB_W-1:0]  db_cnt;
  logic [2:0]            press;

  logic                  dir_q;
  logic [1:0]            speed_q;
  logic                  paused_q;
  logic                  bps_q;
  logic [CNT_W-1:0]      tcnt;
  logic [CNT_W-1:0]      p_last;
  logic                  run;

  // Last count value of a step period at the given speed: (TICK_DIV >> spd) - 1
  function automatic logic [CNT_W-1:0] period_last(input logic [1:0] spd);
    return (TICK_DIV_C >> spd) - CNT_ONE;
  endfunction

  assign key_raw = {bus.key_pause, bus.key_speed, bus.key_dir};

  // Stage p0/p1: two-flop synchroniser, idles at released (1)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_p0 <= 3'b111;
      key_p1 <= 3'b111;
    end else begin
      key_p0 <= key_raw;
      key_p1 <= key_p0;
    end
  end

  // Debounce: a level change is accepted on the edge where the synchronised
  // value has differed for DB_CNT consecutive cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level  <= 3'b111;
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (key_p1[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= key_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_ONE;
        end
      end
    end
  end

  // A press is the accepted 1->0 transition; actions fire on that same edge.
  always_comb begin
    press = '0;
    for (int i = 0; i < 3; i++) begin
      press[i] = level[i] && !key_p1[i] && (db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q    <= 1'b0;
      speed_q  <= 2'd0;
      paused_q <= 1'b0;
    end else begin
      if (press[K_DIR])   dir_q    <= ~dir_q;
      if (press[K_SPEED]) speed_q  <= speed_q + 2'd1;
      if (press[K_PAUSE]) paused_q <= ~paused_q;
    end
  end

  // Counting follows the post-edge pause state: entering pause freezes on the
  // press edge, leaving pause counts on the press edge.
  assign run    = ~(paused_q ^ press[K_PAUSE]);
  assign p_last = period_last(speed_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt  <= '0;
      bps_q <= 1'b0;
    end else if (press[K_SPEED]) begin
      // Speed change restarts the period and overrides a coincident strobe
      tcnt  <= '0;
      bps_q <= 1'b0;
    end else if (!run) begin
      bps_q <= 1'b0;
    end else if (tcnt == p_last) begin
      tcnt  <= '0;
      bps_q <= 1'b1;
    end else begin
      tcnt  <= tcnt + CNT_ONE;
      bps_q <= 1'b0;
    end
  end

  assign bus.dir     = dir_q;
  assign bus.clk_bps = bps_q;
  assign bus.speed   = speed_q;
  assign bus.paused  = paused_q;

endmodule

// File: tb/tb_flash_tick_dir_gen.sv
// Self-checking bench for flash_tick_dir_gen with TICK_DIV=16, DB_CNT=4.
// Cycle numbers count clk edges after reset release; a key driven low just
// after edge k is acted on at edge k+6. Expected strobe edges are queued as
// each scenario is set up and matched as the strobe appears.
module tb_flash_tick_dir_gen;
  localparam int TICK_DIV = 16;
  localparam int DB_CNT   = 4;
  localparam int CNT_W    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flash_tick_dir_gen_if bus();

  flash_tick_dir_gen #(
    .TICK_DIV (TICK_DIV),
    .DB_CNT   (DB_CNT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0] keys;   // bit0 dir, bit1 speed, bit2 pause
    int         hold;
    logic       e_dir;
    logic [1:0] e_speed;
    logic       e_paused;
  } vec_t;

  vec_t vecs [9];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;
  int   exp_q [$];

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int outs();
    return int'({bus.dir, bus.speed, bus.paused});
  endfunction

  task automatic monitor();
    int t;
    while (exp_q.size() > 0 && exp_q[0] < cyc) begin
      t = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL strobe_missing: no clk_bps at cyc %0d (now cyc %0d)", t, cyc);
    end
    if (bus.clk_bps) begin
      n_checks++;
      if (exp_q.size() == 0 || exp_q[0] != cyc) begin
        n_fail++;
        $display("FAIL strobe_unexpected: clk_bps=1 at cyc %0d, next expected %0d",
                 cyc, (exp_q.size() > 0) ? exp_q[0] : -1);
      end else begin
        t = exp_q.pop_front();
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      if (mon_en) monitor();
    end
  endtask

  task automatic step_to(input int c);
    if (c > cyc) step(c - cyc);
  endtask

  task automatic push_run(input int start, input int p, input int lim);
    for (int t = start + p; t < lim; t += p) exp_q.push_back(t);
  endtask

  task automatic keys_idle();
    bus.key_dir   = 1'b1;
    bus.key_speed = 1'b1;
    bus.key_pause = 1'b1;
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_dir"},     int'(bus.dir),     0);
    check_val({tag, "_clk_bps"}, int'(bus.clk_bps), 0);
    check_val({tag, "_speed"},   int'(bus.speed),   0);
    check_val({tag, "_paused"},  int'(bus.paused),  0);
  endtask

  task automatic do_reset(input string tag);
    mon_en = 1'b0;
    exp_q.delete();
    rst = 1'b0;
    #2;
    check_reset_outs(tag);
    step(2);
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    vecs[0] = '{3'b001,  2, 1'b0, 2'd0, 1'b0};  // short dir glitch
    vecs[1] = '{3'b001, 10, 1'b1, 2'd0, 1'b0};  // long dir hold, toggles once
    vecs[2] = '{3'b010,  3, 1'b1, 2'd0, 1'b0};  // DB_CNT-1 cycles: rejected
    vecs[3] = '{3'b010,  4, 1'b1, 2'd1, 1'b0};  // exactly DB_CNT cycles
    vecs[4] = '{3'b110,  8, 1'b1, 2'd2, 1'b1};  // speed + pause together
    vecs[5] = '{3'b100,  6, 1'b1, 2'd2, 1'b0};
    vecs[6] = '{3'b111,  8, 1'b0, 2'd3, 1'b1};  // all three together
    vecs[7] = '{3'b010,  8, 1'b0, 2'd0, 1'b1};  // speed wraps 3->0
    vecs[8] = '{3'b101,  8, 1'b1, 2'd0, 1'b0};

    keys_idle();
    #1;

    // Idle keys: strobes every 16 cycles
    do_reset("rst_a");
    mon_en = 1'b1;
    push_run(0, 16, 101);
    step(100);
    check_val("idle_outs", outs(), 0);

    // Table: debounce acceptance timing and key actions
    do_reset("rst_tab");
    begin
      int prev;
      int last;
      int expv;
      prev = 0;
      for (int i = 0; i < $size(vecs); i++) begin
        expv = int'({vecs[i].e_dir, vecs[i].e_speed, vecs[i].e_paused});
        last = (vecs[i].hold > 6) ? vecs[i].hold : 6;
        bus.key_dir   = ~vecs[i].keys[0];
        bus.key_speed = ~vecs[i].keys[1];
        bus.key_pause = ~vecs[i].keys[2];
        for (int j = 1; j <= last; j++) begin
          step(1);
          if (j == vecs[i].hold) keys_idle();
          if (j == 5) check_val($sformatf("vec%0d_before", i), outs(), prev);
          if (j == 6) check_val($sformatf("vec%0d_at_accept", i), outs(), expv);
        end
        step(10);
        check_val($sformatf("vec%0d_after_release", i), outs(), expv);
        prev = expv;
      end
    end

    // Speed steps: spacing 8, 4, 2, then back to 16; press at 70 lands on tcnt==P-1
    keys_idle();
    do_reset("rst_spd");
    mon_en = 1'b1;
    push_run(0, 16, 26);
    push_run(26, 8, 56);
    push_run(56, 4, 76);
    push_run(76, 2, 96);
    push_run(96, 16, 141);
    begin
      int pt [4];
      pt = '{20, 50, 70, 90};
      for (int i = 0; i < 4; i++) begin
        step_to(pt[i]);
        bus.key_speed = 1'b0;
        step(8);
        bus.key_speed = 1'b1;
      end
    end
    step_to(140);
    check_val("spd_wrapped", int'(bus.speed), 0);

    // Pause at tcnt=5, resume 50 cycles later: next strobe 11 edges on
    do_reset("rst_pause");
    mon_en = 1'b1;
    exp_q.push_back(16);
    push_run(66, 16, 121);
    step_to(16);
    bus.key_pause = 1'b0;
    step(8);
    bus.key_pause = 1'b1;
    step_to(50);
    check_val("pause_held", int'(bus.paused), 1);
    step_to(66);
    bus.key_pause = 1'b0;
    step(8);
    bus.key_pause = 1'b1;
    step_to(120);
    check_val("pause_released", int'(bus.paused), 0);

    // dir + speed together, accepted on tcnt==15: no strobe, then P=8
    do_reset("rst_ds");
    mon_en = 1'b1;
    push_run(0, 16, 32);
    push_run(32, 8, 81);
    step_to(26);
    bus.key_dir   = 1'b0;
    bus.key_speed = 1'b0;
    step(5);
    check_val("ds_before", outs(), int'({1'b0, 2'd0, 1'b0}));
    step(1);
    check_val("ds_at_accept", outs(), int'({1'b1, 2'd1, 1'b0}));
    step(2);
    keys_idle();
    step_to(80);

    // Entering pause on tcnt==15 suppresses the strobe; resuming strobes at once
    do_reset("rst_pe");
    mon_en = 1'b1;
    exp_q.push_back(40);
    exp_q.push_back(56);
    exp_q.push_back(72);
    step_to(10);
    bus.key_pause = 1'b0;
    step(6);
    check_val("pe_paused", int'(bus.paused), 1);
    step(2);
    bus.key_pause = 1'b1;
    step_to(34);
    bus.key_pause = 1'b0;
    step(6);
    check_val("pe_resumed", int'(bus.paused), 0);
    step(2);
    bus.key_pause = 1'b1;
    step_to(80);

    // Reset mid-period with key_dir held: held key counts as a new press
    do_reset("rst_f0");
    mon_en = 1'b1;
    step_to(3);
    bus.key_dir = 1'b0;
    step_to(9);
    check_val("f_dir_toggled", int'(bus.dir), 1);
    do_reset("rst_mid");
    mon_en = 1'b1;
    push_run(0, 16, 41);
    step(5);
    check_val("f_dir_before", int'(bus.dir), 0);
    step(1);
    check_val("f_dir_after", int'(bus.dir), 1);
    step_to(20);
    bus.key_dir = 1'b1;
    step_to(40);
    check_val("f_dir_release", int'(bus.dir), 1);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
